// File: rtl/hazard_control_pkg.sv
// Shared encodings for the hazard_control pipeline sequencer and its forwarding unit.
package hazard_control_pkg;

    localparam int PC_WIDTH = 32;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HC_IDLE  = 1'b0,
        HC_FLUSH = 1'b1
    } hc_state_e;

    // MEM is the younger result, so it wins over WB when both match.
    function automatic fwd_sel_e fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)     return FWD_MEM;
        else if (wb_hit) return FWD_WB;
        else             return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_control_forward.sv
// hc_forward: purely combinational rs/rt operand forwarding select for the EX-stage ALU.
module hc_forward
    import hazard_control_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_ex_rs,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_regwrite,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic                  i_wb_regwrite,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b
);

    logic w_mem_ok;
    logic w_wb_ok;

    // Register 0 is hard-wired, so a write to it must never be forwarded.
    assign w_mem_ok = i_mem_regwrite && (i_mem_rd != '0);
    assign w_wb_ok  = i_wb_regwrite  && (i_wb_rd  != '0);

    assign o_fwd_a = fwd_pick(w_mem_ok && (i_mem_rd == i_ex_rs), w_wb_ok && (i_wb_rd == i_ex_rs));
    assign o_fwd_b = fwd_pick(w_mem_ok && (i_mem_rd == i_ex_rt), w_wb_ok && (i_wb_rd == i_ex_rt));

endmodule

// File: rtl/hazard_control.sv
// hazard_control: load-use bubble, timed redirect squash and forwarding selects around EX.
// Optional performance counters are built when HC_PERF_CNT_EN is defined.
module hazard_control
    import hazard_control_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  hc_i_clk,
    input  logic                  hc_i_rst_n,
    input  logic [REG_ADDR_W-1:0] hc_i_id_rs,
    input  logic [REG_ADDR_W-1:0] hc_i_id_rt,
    input  logic                  hc_i_id_use_rt,
    input  logic                  hc_i_ex_ce,
    input  logic [REG_ADDR_W-1:0] hc_i_ex_rd,
    input  logic                  hc_i_ex_memread,
    input  logic [REG_ADDR_W-1:0] hc_i_ex_rs,
    input  logic [REG_ADDR_W-1:0] hc_i_ex_rt,
    input  logic [REG_ADDR_W-1:0] hc_i_mem_rd,
    input  logic                  hc_i_mem_regwrite,
    input  logic [REG_ADDR_W-1:0] hc_i_wb_rd,
    input  logic                  hc_i_wb_regwrite,
    input  logic                  hc_i_change_pc,
    input  logic [PC_WIDTH-1:0]   hc_i_target_pc,
    output logic                  hc_o_stall_if,
    output logic                  hc_o_stall_id,
    output logic                  hc_o_flush_id,
    output logic                  hc_o_flush_ex,
    output logic                  hc_o_redirect,
    output logic [PC_WIDTH-1:0]   hc_o_redirect_pc,
`ifdef HC_PERF_CNT_EN
    output logic [31:0]           hc_o_stall_cnt,
    output logic [31:0]           hc_o_flush_cnt,
`endif
    output logic [1:0]            hc_o_fwd_a,
    output logic [1:0]            hc_o_fwd_b
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    hc_state_e        r_state;
    hc_state_e        w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             w_load_use;
    logic             w_stall;
    logic             w_flush;
    logic             w_redirect;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    assign w_load_use = hc_i_ex_ce && hc_i_ex_memread && (hc_i_ex_rd != '0) &&
                        ((hc_i_ex_rd == hc_i_id_rs) ||
                         (hc_i_id_use_rt && (hc_i_ex_rd == hc_i_id_rt)));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        w_flush      = 1'b0;
        w_redirect   = 1'b0;
        unique case (r_state)
            HC_IDLE: begin
                if (hc_i_change_pc) begin
                    w_redirect = 1'b1;
                    w_flush    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_next_state = HC_FLUSH;
                        w_next_cnt   = CNT_W'(FLUSH_CYCLES - 1);
                    end
                end else if (w_load_use) begin
                    w_stall = 1'b1;
                end
            end
            HC_FLUSH: begin
                w_flush = 1'b1;
                if (r_cnt <= CNT_W'(1)) begin
                    w_next_state = HC_IDLE;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt   = r_cnt - CNT_W'(1);
                end
            end
            default: w_next_state = HC_IDLE;
        endcase
        // Outputs are forced quiet while reset is held, regardless of inputs.
        if (!hc_i_rst_n) begin
            w_stall    = 1'b0;
            w_flush    = 1'b0;
            w_redirect = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge hc_i_clk or negedge hc_i_rst_n) begin
        if (!hc_i_rst_n) begin
            r_state <= HC_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    hc_forward #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_forward (
        .i_ex_rs       (hc_i_ex_rs),
        .i_ex_rt       (hc_i_ex_rt),
        .i_mem_rd      (hc_i_mem_rd),
        .i_mem_regwrite(hc_i_mem_regwrite),
        .i_wb_rd       (hc_i_wb_rd),
        .i_wb_regwrite (hc_i_wb_regwrite),
        .o_fwd_a       (w_fwd_a),
        .o_fwd_b       (w_fwd_b)
    );

    assign hc_o_stall_if    = w_stall;
    assign hc_o_stall_id    = w_stall;
    assign hc_o_flush_id    = w_flush;
    assign hc_o_flush_ex    = w_flush || w_stall;
    assign hc_o_redirect    = w_redirect;
    assign hc_o_redirect_pc = w_redirect ? hc_i_target_pc : '0;
    assign hc_o_fwd_a       = hc_i_rst_n ? w_fwd_a : FWD_NONE;
    assign hc_o_fwd_b       = hc_i_rst_n ? w_fwd_b : FWD_NONE;

`ifdef HC_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge hc_i_clk or negedge hc_i_rst_n) begin
        if (!hc_i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_redirect && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign hc_o_stall_cnt = r_stall_cnt;
    assign hc_o_flush_cnt = r_flush_cnt;
`endif

endmodule
